// File: rtl/rf_wb_arbiter_pkg.sv
// Shared writeback constants, source encoding and the register one-hot helper.
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } wb_src_e;

    // One-hot of a destination register; x0 never shows as pending.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_WIDTH-1:0] a);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (a != '0) begin
            m[a] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_fifo.sv
// Small writeback buffer: async-reset synchronous FIFO holding {rd, data} entries.
// Exposes every slot's rd and occupancy so the top can build the pending mask.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    parameter int AW    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [W-1:0]        push_entry,
    input  logic                pop,
    output logic [W-1:0]        head,
    output logic                valid,
    output logic                full,
    output logic [DEPTH*AW-1:0] entry_rd,
    output logic [DEPTH-1:0]    entry_vld
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // Pointer and occupancy control; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] off;
        off       = '0;
        entry_rd  = '0;
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off                  = PW'(i) - rd_ptr;
            entry_vld[i]         = (CW'(off) < count);
            entry_rd[i*AW +: AW] = mem[i][W-1 -: AW];
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the ALU and LSU writeback buffers.
// LSU wins by default; the ALU is forced through after STARVE_MAX consecutive losses.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = REG_ADDR_WIDTH,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_rd,
    input  logic [DW-1:0]       alu_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [AW-1:0]       lsu_rd,
    input  logic [DW-1:0]       lsu_data,
    output logic                reg_wen,
    output logic [AW-1:0]       rd,
    output logic [DW-1:0]       data_in,
    output logic                wb_src,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                idle
);

    localparam int EW = DW + AW;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic                alu_push, lsu_push;
    logic                alu_pop, lsu_pop;
    logic                alu_full, lsu_full;
    logic                alu_hv, lsu_hv;
    logic [EW-1:0]       alu_head, lsu_head;
    logic [DEPTH*AW-1:0] alu_erd, lsu_erd;
    logic [DEPTH-1:0]    alu_evld, lsu_evld;
    logic                alu_win, lsu_win;
    logic [SW-1:0]       starve_cnt;

    assign alu_ready = !alu_full;
    assign lsu_ready = !lsu_full;

    // x0 writes complete the handshake but are dropped here.
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != '0);

    wb_fifo #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (alu_push),
        .push_entry ({alu_rd, alu_data}),
        .pop        (alu_pop),
        .head       (alu_head),
        .valid      (alu_hv),
        .full       (alu_full),
        .entry_rd   (alu_erd),
        .entry_vld  (alu_evld)
    );

    wb_fifo #(.W(EW), .DEPTH(DEPTH), .AW(AW)) u_lsu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (lsu_push),
        .push_entry ({lsu_rd, lsu_data}),
        .pop        (lsu_pop),
        .head       (lsu_head),
        .valid      (lsu_hv),
        .full       (lsu_full),
        .entry_rd   (lsu_erd),
        .entry_vld  (lsu_evld)
    );

    // Grant and write-port drive; nothing is written while reset is held.
    always_comb begin
        alu_win = alu_hv && (!lsu_hv || (starve_cnt == SW'(STARVE_MAX)));
        lsu_win = lsu_hv && !alu_win;
        reg_wen = (alu_win || lsu_win) && !rst;
        wb_src  = SRC_ALU;
        rd      = '0;
        data_in = '0;
        if (lsu_win) begin
            wb_src  = SRC_LSU;
            rd      = lsu_head[EW-1 -: AW];
            data_in = lsu_head[DW-1:0];
        end else if (alu_win) begin
            rd      = alu_head[EW-1 -: AW];
            data_in = alu_head[DW-1:0];
        end
    end

    assign alu_pop = alu_win;
    assign lsu_pop = lsu_win;
    assign idle    = !alu_hv && !lsu_hv;

    // Count consecutive ALU losses while it has a head; any ALU win clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (alu_win) begin
            starve_cnt <= '0;
        end else if (alu_hv && lsu_win && (starve_cnt != SW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Pending mask is the OR of every live buffered destination in both sources.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_evld[i]) begin
                pend_mask = pend_mask | rd_onehot(alu_erd[i*AW +: AW]);
            end
            if (lsu_evld[i]) begin
                pend_mask = pend_mask | rd_onehot(lsu_erd[i*AW +: AW]);
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with hand-derived expected write sequences.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [31:0] data_in;
    logic        wb_src;
    logic [31:0] pend_mask;
    logic        idle;

    int n_vec = 0;
    int n_mis = 0;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .reg_wen   (reg_wen),
        .rd        (rd),
        .data_in   (data_in),
        .wb_src    (wb_src),
        .pend_mask (pend_mask),
        .idle      (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_wb(input string tag, input logic exp_wen, input logic [4:0] exp_rd,
                            input logic [31:0] exp_data, input logic exp_src);
        check_vec({tag, ".wen"}, 64'(reg_wen), 64'(exp_wen));
        if (exp_wen) begin
            check_vec({tag, ".rd"},   64'(rd),      64'(exp_rd));
            check_vec({tag, ".data"}, 64'(data_in), 64'(exp_data));
            check_vec({tag, ".src"},  64'(wb_src),  64'(exp_src));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = r;
        alu_data  = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] r, input logic [31:0] d);
        lsu_valid = v;
        lsu_rd    = r;
        lsu_data  = d;
    endtask

    initial begin
        rst = 1'b1;
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_vec("rst.wen",  64'(reg_wen),   64'd0);
        check_vec("rst.idle", 64'(idle),      64'd1);
        check_vec("rst.pend", 64'(pend_mask), 64'd0);
        check_vec("rst.ardy", 64'(alu_ready), 64'd1);
        check_vec("rst.lrdy", 64'(lsu_ready), 64'd1);

        // 1: single ALU write
        drive_alu(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check_wb("t1.w", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0);
        check_vec("t1.pend", 64'(pend_mask), 64'h20);
        check_vec("t1.idle", 64'(idle), 64'd0);
        tick();
        check_wb("t1.after", 1'b0, 5'd0, 32'h0, 1'b0);
        check_vec("t1.pend0", 64'(pend_mask), 64'h0);
        check_vec("t1.idle1", 64'(idle), 64'd1);

        // 2: simultaneous ALU and LSU push, LSU first
        drive_alu(1'b1, 5'd3, 32'h0000_0033);
        drive_lsu(1'b1, 5'd4, 32'h0000_0044);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        check_wb("t2.lsu", 1'b1, 5'd4, 32'h44, 1'b1);
        check_vec("t2.pend", 64'(pend_mask), 64'h18);
        tick();
        check_wb("t2.alu", 1'b1, 5'd3, 32'h33, 1'b0);
        tick();
        check_wb("t2.idle", 1'b0, 5'd0, 32'h0, 1'b0);

        // 3: LSU streams, ALU loses three times then wins
        drive_alu(1'b1, 5'd7, 32'h0000_00A7);
        drive_lsu(1'b1, 5'd8, 32'h0000_0100);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b1, 5'd9, 32'h0000_0101);
        for (int k = 0; k < 3; k++) begin
            check_wb($sformatf("t3.lsu%0d", k), 1'b1, 5'(8 + k), 32'h100 + 32'(k), 1'b1);
            tick();
            drive_lsu(1'b1, 5'(10 + k), 32'h102 + 32'(k));
        end
        check_wb("t3.alu", 1'b1, 5'd7, 32'hA7, 1'b0);
        check_vec("t3.lrdy", 64'(lsu_ready), 64'd1);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        check_wb("t3.l3", 1'b1, 5'd11, 32'h103, 1'b1);
        check_vec("t3.lfull", 64'(lsu_ready), 64'd0);
        tick();
        check_wb("t3.l4", 1'b1, 5'd12, 32'h104, 1'b1);
        tick();
        check_vec("t3.idle", 64'(idle), 64'd1);

        // 4: three ALU pushes against a saturating LSU
        drive_alu(1'b1, 5'd10, 32'hA0);
        drive_lsu(1'b1, 5'd20, 32'hB0);
        tick();
        check_vec("t4.ardy1", 64'(alu_ready), 64'd1);
        drive_alu(1'b1, 5'd11, 32'hA1);
        drive_lsu(1'b1, 5'd21, 32'hB1);
        check_wb("t4.c1", 1'b1, 5'd20, 32'hB0, 1'b1);
        tick();
        drive_alu(1'b1, 5'd12, 32'hA2);
        drive_lsu(1'b1, 5'd22, 32'hB2);
        check_vec("t4.ardy2", 64'(alu_ready), 64'd0);
        check_wb("t4.c2", 1'b1, 5'd21, 32'hB1, 1'b1);
        tick();
        drive_lsu(1'b1, 5'd23, 32'hB3);
        check_vec("t4.ardy3", 64'(alu_ready), 64'd0);
        check_wb("t4.c3", 1'b1, 5'd22, 32'hB2, 1'b1);
        tick();
        drive_lsu(1'b1, 5'd24, 32'hB4);
        check_vec("t4.ardy4", 64'(alu_ready), 64'd0);
        check_wb("t4.c4", 1'b1, 5'd10, 32'hA0, 1'b0);
        tick();
        drive_lsu(1'b0, 5'd0, 32'h0);
        check_vec("t4.ardy5", 64'(alu_ready), 64'd1);
        check_wb("t4.c5", 1'b1, 5'd23, 32'hB3, 1'b1);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check_wb("t4.c6", 1'b1, 5'd24, 32'hB4, 1'b1);
        tick();
        check_wb("t4.c7", 1'b1, 5'd11, 32'hA1, 1'b0);
        tick();
        check_wb("t4.c8", 1'b1, 5'd12, 32'hA2, 1'b0);
        tick();
        check_vec("t4.idle", 64'(idle), 64'd1);

        // 5: x0 write is swallowed
        drive_alu(1'b1, 5'd0, 32'h0000_1234);
        check_vec("t5.ardy", 64'(alu_ready), 64'd1);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check_wb("t5.c1", 1'b0, 5'd0, 32'h0, 1'b0);
        check_vec("t5.pend", 64'(pend_mask), 64'h0);
        check_vec("t5.idle", 64'(idle), 64'd1);
        tick();
        check_wb("t5.c2", 1'b0, 5'd0, 32'h0, 1'b0);

        // 6: asynchronous reset with buffered writes
        drive_alu(1'b1, 5'd1, 32'h11);
        drive_lsu(1'b1, 5'd2, 32'h22);
        tick();
        drive_alu(1'b1, 5'd3, 32'h33);
        drive_lsu(1'b1, 5'd4, 32'h44);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_lsu(1'b0, 5'd0, 32'h0);
        check_vec("t6.ardy", 64'(alu_ready), 64'd0);
        check_vec("t6.pend", 64'(pend_mask), 64'h1A);
        rst = 1'b1;
        #1;
        check_vec("t6.rwen",  64'(reg_wen),   64'd0);
        check_vec("t6.ridle", 64'(idle),      64'd1);
        check_vec("t6.rpend", 64'(pend_mask), 64'd0);
        check_vec("t6.rardy", 64'(alu_ready), 64'd1);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check_wb($sformatf("t6.post%0d", k), 1'b0, 5'd0, 32'h0, 1'b0);
            check_vec($sformatf("t6.idle%0d", k), 64'(idle), 64'd1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
